// File: rtl/poly_pkg.sv
// poly_pkg: shared widths, default voice count and note/velocity types for the polyphony stage
package poly_pkg;
    localparam int DEF_VOICES = 4;
    localparam int NOTE_W = 7;
    localparam int VEL_W = 7;
    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [VEL_W-1:0] vel_t;
endpackage

// File: rtl/poly_lru.sv
// poly_lru: least-recently-used rank keeper; rank 0 = most recent, VOICES-1 = oldest
//  clk, rst   clock, async active-high reset (rank[i] = i)
//  touch      move touch_idx to rank 0 this cycle
//  touch_idx  voice being (re)started
//  oldest_idx voice currently holding rank VOICES-1
//  rank       voice i rank at [i*RANK_W +: RANK_W]
module poly_lru #(
    parameter int VOICES = 4,
    localparam int RANK_W = $clog2(VOICES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     touch,
    input  logic [RANK_W-1:0]        touch_idx,
    output logic [RANK_W-1:0]        oldest_idx,
    output logic [VOICES*RANK_W-1:0] rank
);
    logic [RANK_W-1:0] rank_q [VOICES];

    // Only voices more recent than the touched one age, so ranks stay a permutation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) rank_q[i] <= RANK_W'(i);
        end else if (touch) begin
            for (int i = 0; i < VOICES; i++)
                rank_q[i] <= (RANK_W'(i) == touch_idx) ? '0 :
                             (rank_q[i] < rank_q[touch_idx]) ? rank_q[i] + 1'b1 : rank_q[i];
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < VOICES; i++)
            if (rank_q[i] == RANK_W'(VOICES - 1)) oldest_idx = RANK_W'(i);
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_rank
        assign rank[v*RANK_W +: RANK_W] = rank_q[v];
    end
endmodule

// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: N-voice allocator with LRU stealing, retrigger and sustain hold
//  clk, rst, ce          clock, async active-high reset, clock enable
//  note_on/note_off      one-ce-cycle event strobes with note_num/note_vel
//  sustain               pedal level, falling edge releases held voices
//  voice_note/voice_vel  per-voice note and velocity, voice i at [i*W +: W]
//  voice_gate/voice_trig per-voice sounding flag and (re)start pulse
//  all_busy              every gate high, next new note steals
module poly_voice_alloc
    import poly_pkg::*;
#(
    parameter int VOICES = DEF_VOICES,
    parameter int NOTE_W = poly_pkg::NOTE_W,
    parameter int VEL_W  = poly_pkg::VEL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     note_on,
    input  logic                     note_off,
    input  logic [NOTE_W-1:0]        note_num,
    input  logic [VEL_W-1:0]         note_vel,
    input  logic                     sustain,
    output logic [VOICES*NOTE_W-1:0] voice_note,
    output logic [VOICES*VEL_W-1:0]  voice_vel,
    output logic [VOICES-1:0]        voice_gate,
    output logic [VOICES-1:0]        voice_trig,
    output logic                     all_busy
);
    localparam int RANK_W = $clog2(VOICES);

    logic [NOTE_W-1:0] note_q [VOICES], note_d [VOICES];
    logic [VEL_W-1:0]  vel_q [VOICES], vel_d [VOICES];
    logic [VOICES-1:0] gate_q, gate_d, held_q, held_d, trig_q, trig_d, hit, free;
    logic              sus_q, busy_q, is_on, is_off, fall;
    logic [RANK_W-1:0] hit_idx, free_idx, oldest_idx, tgt;
    logic [VOICES*RANK_W-1:0] rank_unused;

    poly_lru #(.VOICES(VOICES)) u_lru (
        .clk       (clk),
        .rst       (rst),
        .touch     (ce & is_on),
        .touch_idx (tgt),
        .oldest_idx(oldest_idx),
        .rank      (rank_unused)
    );

    always_comb begin
        is_on  = note_on && note_vel != '0;
        is_off = (note_off && !note_on) || (note_on && note_vel == '0);
        fall   = sus_q && !sustain;
        for (int i = 0; i < VOICES; i++) begin
            hit[i]  = gate_q[i] && note_q[i] == note_num;
            free[i] = !gate_q[i];
        end
        hit_idx  = '0;
        free_idx = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = RANK_W'(i);
            if (free[i]) free_idx = RANK_W'(i);
        end
        tgt = |hit ? hit_idx : |free ? free_idx : oldest_idx;
        note_d = note_q;
        vel_d  = vel_q;
        gate_d = gate_q;
        held_d = held_q;
        trig_d = '0;
        // Pedal release first so a same-cycle note_on target ends up sounding and unheld.
        for (int i = 0; i < VOICES; i++) begin
            if (fall && held_q[i]) begin
                gate_d[i] = 1'b0;
                held_d[i] = 1'b0;
            end
            if (is_off && hit[i]) begin
                gate_d[i] = sustain;
                held_d[i] = sustain;
            end
        end
        if (is_on) begin
            note_d[tgt] = note_num;
            vel_d[tgt]  = note_vel;
            gate_d[tgt] = 1'b1;
            held_d[tgt] = 1'b0;
            trig_d[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
            end
            gate_q <= '0;
            held_q <= '0;
            trig_q <= '0;
            sus_q  <= 1'b0;
            busy_q <= 1'b0;
        end else if (ce) begin
            note_q <= note_d;
            vel_q  <= vel_d;
            gate_q <= gate_d;
            held_q <= held_d;
            trig_q <= trig_d;
            sus_q  <= sustain;
            busy_q <= &gate_d;
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_out
        assign voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
        assign voice_vel[v*VEL_W +: VEL_W]    = vel_q[v];
    end
    assign voice_gate = gate_q;
    assign voice_trig = trig_q;
    assign all_busy   = busy_q;
endmodule

// File: tb/tb_poly_voice_alloc.sv
// tb_poly_voice_alloc: directed and random stimulus against a recency-list reference model
module tb_poly_voice_alloc;
    localparam int V = 4, NW = 7, VW = 7, RW = 2;

    logic clk = 1'b0, rst = 1'b1, ce = 1'b0, note_on = 1'b0, note_off = 1'b0, sustain = 1'b0;
    logic [NW-1:0] note_num = '0;
    logic [VW-1:0] note_vel = '0;
    logic [V*NW-1:0] voice_note;
    logic [V*VW-1:0] voice_vel;
    logic [V-1:0] voice_gate, voice_trig;
    logic all_busy;

    poly_voice_alloc #(.VOICES(V)) dut (
        .clk(clk), .rst(rst), .ce(ce), .note_on(note_on), .note_off(note_off),
        .note_num(note_num), .note_vel(note_vel), .sustain(sustain),
        .voice_note(voice_note), .voice_vel(voice_vel), .voice_gate(voice_gate),
        .voice_trig(voice_trig), .all_busy(all_busy)
    );

    always #5 clk = ~clk;

    int m_note [V], m_vel [V];
    bit m_gate [V], m_held [V], m_trig [V];
    bit m_sus;
    int order [$];
    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < V; i++) begin
            m_note[i] = 0; m_vel[i] = 0; m_gate[i] = 0; m_held[i] = 0; m_trig[i] = 0;
        end
        m_sus = 0;
        order = {};
        for (int i = 0; i < V; i++) order.push_back(i);
    endfunction

    function automatic void m_step(bit on, bit off, int num, int vel, bit sus);
        bit is_on, is_off;
        int hit, free, tgt;
        is_on = on && vel != 0;
        is_off = (off && !on) || (on && vel == 0);
        hit = -1;
        free = -1;
        for (int i = 0; i < V; i++) begin
            if (hit < 0 && m_gate[i] && m_note[i] == num) hit = i;
            if (free < 0 && !m_gate[i]) free = i;
            m_trig[i] = 0;
        end
        if (m_sus && !sus)
            for (int i = 0; i < V; i++)
                if (m_held[i]) begin m_gate[i] = 0; m_held[i] = 0; end
        if (is_off && hit >= 0) begin
            if (sus) m_held[hit] = 1;
            else begin m_gate[hit] = 0; m_held[hit] = 0; end
        end
        if (is_on) begin
            tgt = hit >= 0 ? hit : free >= 0 ? free : order[$];
            m_note[tgt] = num; m_vel[tgt] = vel; m_gate[tgt] = 1; m_held[tgt] = 0; m_trig[tgt] = 1;
            for (int k = 0; k < order.size(); k++)
                if (order[k] == tgt) begin order.delete(k); break; end
            order.push_front(tgt);
        end
        m_sus = sus;
    endfunction

    task automatic check_all(input string tag);
        logic [V*NW-1:0] en;
        logic [V*VW-1:0] ev;
        logic [V-1:0] eg, et;
        logic [V*RW-1:0] er;
        for (int i = 0; i < V; i++) begin
            en[i*NW +: NW] = NW'(m_note[i]);
            ev[i*VW +: VW] = VW'(m_vel[i]);
            eg[i] = m_gate[i];
            et[i] = m_trig[i];
        end
        for (int k = 0; k < V; k++) er[order[k]*RW +: RW] = RW'(k);
        chk({tag, ".note"}, 64'(voice_note), 64'(en));
        chk({tag, ".vel"}, 64'(voice_vel), 64'(ev));
        chk({tag, ".gate"}, 64'(voice_gate), 64'(eg));
        chk({tag, ".trig"}, 64'(voice_trig), 64'(et));
        chk({tag, ".busy"}, 64'(all_busy), 64'(&eg));
        chk({tag, ".rank"}, 64'(dut.u_lru.rank), 64'(er));
    endtask

    task automatic step(input string tag, input bit on, input bit off, input int num,
                        input int vel, input bit s, input bit c = 1'b1);
        @(negedge clk);
        note_on = on; note_off = off; note_num = NW'(num); note_vel = VW'(vel);
        sustain = s; ce = c;
        @(posedge clk);
        if (c) m_step(on, off, num, vel, s);
        #1;
        note_on = 1'b0; note_off = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; ce = 1'b0; note_on = 1'b0; note_off = 1'b0; sustain = 1'b0;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all(tag);
    endtask

    initial begin
        bit sus_r;
        int r;
        m_reset();
        do_reset("reset");

        step("t1a", 1, 0, 60, 100, 0);
        step("t1b", 1, 0, 62, 90, 0);
        step("t1c", 1, 0, 64, 80, 0);
        chk("t1.gates", 64'(voice_gate), 64'b0111);

        do_reset("t2.rst");
        step("t2a", 1, 0, 60, 10, 0);
        step("t2b", 1, 0, 62, 20, 0);
        step("t2c", 1, 0, 64, 30, 0);
        step("t2d", 1, 0, 65, 40, 0);
        step("t2e", 1, 0, 67, 50, 0);
        chk("t2.steal_note0", 64'(voice_note[6:0]), 64'd67);
        chk("t2.all_busy", 64'(all_busy), 64'd1);

        do_reset("t3.rst");
        step("t3a", 1, 0, 60, 100, 0);
        step("t3b", 1, 0, 60, 40, 0);
        chk("t3.vel0", 64'(voice_vel[6:0]), 64'd40);
        chk("t3.gate1", 64'(voice_gate[1]), 64'd0);

        do_reset("t4.rst");
        step("t4a", 1, 0, 60, 100, 0);
        step("t4b", 1, 0, 62, 100, 0);
        step("t4c", 0, 1, 60, 0, 0);
        chk("t4.note0_kept", 64'(voice_note[6:0]), 64'd60);
        step("t4d", 1, 0, 64, 100, 0);
        chk("t4.reuse0", 64'(voice_note[6:0]), 64'd64);

        do_reset("t5.rst");
        step("t5a", 0, 0, 0, 0, 1);
        step("t5b", 1, 0, 60, 100, 1);
        step("t5c", 0, 1, 60, 0, 1);
        chk("t5.held_gate", 64'(voice_gate[0]), 64'd1);
        step("t5d", 0, 0, 0, 0, 0);
        chk("t5.release", 64'(voice_gate[0]), 64'd0);

        do_reset("t6.rst");
        step("t6a", 1, 0, 70, 50, 0, 0);
        step("t6b", 1, 0, 60, 100, 0);
        step("t6c", 1, 0, 64, 100, 0);
        step("t6d", 1, 0, 67, 100, 0);
        #2 rst = 1'b1;
        #1 m_reset();
        check_all("t6.async");
        @(negedge clk);
        rst = 1'b0;

        sus_r = 0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 11) == 0) sus_r = ~sus_r;
            step("rnd", r < 5 || r == 9, r >= 5, 60 + $urandom_range(0, 6),
                 $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 127), sus_r,
                 $urandom_range(0, 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
